puzzle_ctrl: RTL

Game-logic engine for the 2x2 sliding-tile puzzle, directly upstream of the VGA renderer. It debounces the five push-buttons and keeps the tile layout. It performs blank-tile moves and LFSR shuffles, and drives the 12-bit `img_nums` layout word that the renderer uses to pick each screen quadrant's image.

---
 rtl/puzzle_ctrl_if.sv | 22 ++
 rtl/puzzle_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/puzzle_ctrl_if.sv
// Button inputs and layout/status outputs of the 2x2 sliding-tile engine.
interface puzzle_ctrl_if;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        btn_shuffle;
    logic [11:0] img_nums;
    logic [7:0]  move_cnt;
    logic        solved;
    logic        shuffling;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_shuffle,
        input  img_nums, move_cnt, solved, shuffling
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_shuffle,
        output img_nums, move_cnt, solved, shuffling
    );
endinterface

// File: rtl/puzzle_ctrl.sv
// 2x2 sliding-tile game engine: button debounce, blank moves,
// LFSR shuffle and the registered img_nums layout word.
module puzzle_ctrl #(
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter int          SHUF_MOVES      = 32,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    puzzle_ctrl_if.slave bus
);

    localparam int          DW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int          SW     = $clog2(SHUF_MOVES + 1);
    localparam logic [11:0] SOLVED = 12'h054;

    typedef enum logic [1:0] {
        S_PLAY,
        S_SHUF,
        S_WON
    } state_t;

    logic [4:0]    w_raw;
    logic [4:0]    r_s1;
    logic [4:0]    r_s2;
    logic [4:0]    r_db;
    logic [4:0]    r_press;
    logic [DW-1:0] r_dcnt [5];

    state_t        r_state;
    logic [11:0]   r_img;
    logic [7:0]    r_mcnt;
    logic          r_solved;
    logic          r_shuffling;
    logic [SW-1:0] r_scnt;
    logic [15:0]   r_lfsr;

    logic [1:0]    w_blank;
    logic          w_vert;
    logic          w_legal;
    logic [11:0]   w_move_img;
    logic [11:0]   w_shuf_img;
    logic          w_fb;

    // bit order: 0 up, 1 down, 2 left, 3 right, 4 shuffle
    assign w_raw = {bus.btn_shuffle, bus.btn_right, bus.btn_left,
                    bus.btn_down, bus.btn_up};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_db    <= '0;
            r_press <= '0;
            for (int i = 0; i < 5; i++) r_dcnt[i] <= '0;
        end else begin
            r_s1    <= w_raw;
            r_s2    <= r_s1;
            r_press <= '0;
            for (int i = 0; i < 5; i++) begin
                if (r_s2[i] != r_db[i]) begin
                    if (r_dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                        r_dcnt[i]  <= '0;
                        r_db[i]    <= r_s2[i];
                        r_press[i] <= r_s2[i];
                    end else begin
                        r_dcnt[i] <= r_dcnt[i] + DW'(1);
                    end
                end else begin
                    r_dcnt[i] <= '0;
                end
            end
        end
    end

    function automatic logic [1:0] f_blank(input logic [11:0] v);
        logic [1:0] p;
        p = 2'd0;
        for (int i = 0; i < 4; i++)
            if (v[11-3*i -: 3] == 3'd4) p = 2'(i);
        return p;
    endfunction

    function automatic logic [11:0] f_swap(input logic [11:0] v,
                                          input logic [1:0]  p,
                                          input logic [1:0]  q);
        logic [2:0] f [4];
        for (int i = 0; i < 4; i++) f[i] = v[11-3*i -: 3];
        f[p] = f[q];
        f[q] = 3'd4;
        return {f[0], f[1], f[2], f[3]};
    endfunction

    // Vertical neighbour is pos^2, horizontal neighbour is pos^1.
    always_comb begin
        w_blank = f_blank(r_img);
        w_vert  = 1'b0;
        w_legal = 1'b0;
        if (r_press[0]) begin
            w_vert  = 1'b1;
            w_legal = w_blank[1];
        end else if (r_press[1]) begin
            w_vert  = 1'b1;
            w_legal = ~w_blank[1];
        end else if (r_press[2]) begin
            w_legal = w_blank[0];
        end else if (r_press[3]) begin
            w_legal = ~w_blank[0];
        end
        w_move_img = f_swap(r_img, w_blank,
                            w_vert ? (w_blank ^ 2'd2) : (w_blank ^ 2'd1));
        w_shuf_img = f_swap(r_img, w_blank,
                            r_lfsr[0] ? (w_blank ^ 2'd2) : (w_blank ^ 2'd1));
        w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_PLAY;
            r_img       <= SOLVED;
            r_mcnt      <= 8'd0;
            r_solved    <= 1'b1;
            r_shuffling <= 1'b0;
            r_scnt      <= '0;
            r_lfsr      <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
            case (r_state)
                S_PLAY, S_WON: begin
                    if (r_press[4]) begin
                        r_state     <= S_SHUF;
                        r_mcnt      <= 8'd0;
                        r_scnt      <= SW'(SHUF_MOVES);
                        r_solved    <= 1'b0;
                        r_shuffling <= 1'b1;
                    end else if (r_state == S_PLAY && w_legal) begin
                        r_img    <= w_move_img;
                        r_solved <= (w_move_img == SOLVED);
                        if (r_mcnt != 8'hFF) r_mcnt <= r_mcnt + 8'd1;
                        if (w_move_img == SOLVED) r_state <= S_WON;
                    end
                end
                S_SHUF: begin
                    r_img    <= w_shuf_img;
                    r_solved <= 1'b0;
                    if (r_scnt != '0) begin
                        r_scnt <= r_scnt - SW'(1);
                        // landing on the solved layout costs one extra move
                        if (r_scnt == SW'(1) && w_shuf_img != SOLVED) begin
                            r_state     <= S_PLAY;
                            r_shuffling <= 1'b0;
                        end
                    end else begin
                        r_state     <= S_PLAY;
                        r_shuffling <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_PLAY;
                    r_shuffling <= 1'b0;
                end
            endcase
        end
    end

    assign bus.img_nums  = r_img;
    assign bus.move_cnt  = r_mcnt;
    assign bus.solved    = r_solved;
    assign bus.shuffling = r_shuffling;

endmodule
